// File: rtl/knn_vote_selector.sv
// KNN vote selector: keeps the K nearest (distance, label) samples
// and majority-votes the label once end_of_data closes the query.
module knn_vote_selector #(
  parameter int W         = 16,
  parameter int TYPE_W    = 2,
  parameter int K         = 3,
  parameter int NUM_TYPES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     done,
  input  logic [W-1:0]             distance,
  input  logic [TYPE_W-1:0]        data_type,
  input  logic                     end_of_data,
  output logic                     busy,
  output logic [$clog2(K+1)-1:0]   neighbor_count,
  output logic [TYPE_W-1:0]        result_type,
  output logic [$clog2(K+1)-1:0]   result_votes,
  output logic                     result_valid
);

  localparam int CW = $clog2(K+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VOTE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]      r_dist [K];
  logic [TYPE_W-1:0] r_type [K];
  logic [K-1:0]      r_vld;
  logic [CW-1:0]     r_cnt;

  logic [TYPE_W-1:0] r_t;
  logic [TYPE_W-1:0] r_best_t;
  logic [CW-1:0]     r_best_c;
  logic [TYPE_W-1:0] r_res_t;
  logic [CW-1:0]     r_res_c;
  logic              r_valid;

  logic [K-1:0]      w_le;
  logic [K-1:0]      w_at;
  logic [CW-1:0]     w_cnt;
  logic              w_upd;
  logic              w_last;
  logic              w_ins;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (!start && end_of_data) w_next = S_VOTE;
      S_VOTE: begin
        if (start)       w_next = S_COLLECT;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:    w_next = start ? S_COLLECT : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // w_le is a thermometer over the sorted list; the new
  // sample lands at the first position whose bit is clear.
  always_comb begin
    w_le = '0;
    w_at = '0;
    for (int i = 0; i < K; i++)
      w_le[i] = r_vld[i] && (r_dist[i] <= distance);
    w_at[0] = !w_le[0];
    for (int i = 1; i < K; i++)
      w_at[i] = w_le[i-1] && !w_le[i];
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < K; i++)
      if (r_vld[i] && (r_type[i] == r_t))
        w_cnt = w_cnt + 1'b1;
    w_upd  = w_cnt > r_best_c;
    w_last = r_t == TYPE_W'(NUM_TYPES - 1);
  end

  assign w_ins = (r_state == S_COLLECT) && done && !start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        r_dist[i] <= '1;
        r_type[i] <= '0;
      end
      r_vld    <= '0;
      r_cnt    <= '0;
      r_t      <= '0;
      r_best_t <= '0;
      r_best_c <= '0;
      r_res_t  <= '0;
      r_res_c  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (start) begin
        for (int i = 0; i < K; i++) begin
          r_dist[i] <= '1;
          r_type[i] <= '0;
        end
        r_vld <= '0;
        r_cnt <= '0;
      end else if (w_ins) begin
        for (int i = 1; i < K; i++)
          if (!w_le[i] && !w_at[i]) begin
            r_dist[i] <= r_dist[i-1];
            r_type[i] <= r_type[i-1];
            r_vld[i]  <= r_vld[i-1];
          end
        for (int i = 0; i < K; i++)
          if (w_at[i]) begin
            r_dist[i] <= distance;
            r_type[i] <= data_type;
            r_vld[i]  <= 1'b1;
          end
        if (r_cnt != CW'(K))
          r_cnt <= r_cnt + 1'b1;
      end
      if (r_state != S_VOTE) begin
        r_t      <= '0;
        r_best_t <= '0;
        r_best_c <= '0;
      end else begin
        r_t <= r_t + 1'b1;
        if (w_upd) begin
          r_best_t <= r_t;
          r_best_c <= w_cnt;
        end
        if (w_last && !start) begin
          r_res_t <= w_upd ? r_t : r_best_t;
          r_res_c <= w_upd ? w_cnt : r_best_c;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign busy           = (r_state == S_COLLECT) || (r_state == S_VOTE);
  assign neighbor_count = r_cnt;
  assign result_type    = r_res_t;
  assign result_votes   = r_res_c;
  assign result_valid   = r_valid && !start;

endmodule

// File: tb/tb_knn_vote_selector.sv
// Randomized scoreboard bench for knn_vote_selector against a
// queue-based nearest-neighbour / majority-vote reference model.
module tb_knn_vote_selector;

  localparam int W  = 16;
  localparam int TW = 2;
  localparam int K  = 3;
  localparam int NT = 4;
  localparam int CW = $clog2(K+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          done = 1'b0;
  logic [W-1:0]  distance = '0;
  logic [TW-1:0] data_type = '0;
  logic          end_of_data = 1'b0;
  logic          busy;
  logic [CW-1:0] neighbor_count;
  logic [TW-1:0] result_type;
  logic [CW-1:0] result_votes;
  logic          result_valid;

  knn_vote_selector #(
    .W(W), .TYPE_W(TW), .K(K), .NUM_TYPES(NT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .done(done),
    .distance(distance),
    .data_type(data_type),
    .end_of_data(end_of_data),
    .busy(busy),
    .neighbor_count(neighbor_count),
    .result_type(result_type),
    .result_votes(result_votes),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     t;
    int     v;
    longint cy;
  } exp_t;

  exp_t   sb[$];
  int     md[$];
  int     mt[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void m_clear;
    md.delete();
    mt.delete();
  endfunction

  function automatic void m_insert(int d, int t);
    int p = 0;
    foreach (md[i]) if (md[i] <= d) p++;
    if (p < K) begin
      md.insert(p, d);
      mt.insert(p, t);
      if (md.size() > K) begin
        void'(md.pop_back());
        void'(mt.pop_back());
      end
    end
  endfunction

  // eod is driven now and sampled at edge cyc+1
  function automatic void m_push;
    int cnt;
    exp_t e;
    e.t = 0;
    e.v = 0;
    for (int t = 0; t < NT; t++) begin
      cnt = 0;
      foreach (mt[i]) if (mt[i] == t) cnt++;
      if (cnt > e.v) begin
        e.t = t;
        e.v = cnt;
      end
    end
    e.cy = cyc + 1 + NT;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst && result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_type", result_type, e.t);
        chk("result_votes", result_votes, e.v);
        chk("valid_cycle", cyc[31:0], e.cy[31:0]);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_clear();
    chk("busy_after_start", busy, 1);
    chk("count_after_start", neighbor_count, 0);
  endtask

  task automatic send(int d, int t, bit eod);
    done        = 1'b1;
    distance    = W'(d);
    data_type   = TW'(t);
    end_of_data = eod;
    m_insert(d, t);
    if (eod) m_push();
    tick();
    done        = 1'b0;
    end_of_data = 1'b0;
    chk("neighbor_count", neighbor_count, md.size());
  endtask

  task automatic send_eod(bit push);
    end_of_data = 1'b1;
    if (push) m_push();
    tick();
    end_of_data = 1'b0;
  endtask

  task automatic wait_result;
    int n = 0;
    while (sb.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      chk("result_timeout", 0, 1);
      sb.delete();
    end
    chk("busy_idle", busy, 0);
    chk("valid_one_cycle", result_valid, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_count", neighbor_count, 0);
    chk("rst_type", result_type, 0);
    chk("rst_votes", result_votes, 0);
    chk("rst_valid", result_valid, 0);
    rst = 1'b1;
    tick();

    do_start();
    send(50, 1, 0);
    send(10, 2, 0);
    send(30, 1, 0);
    send(20, 2, 0);
    send(40, 3, 0);
    send_eod(1);
    wait_result();

    do_start();
    send(7, 1, 0);
    send(3, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_count", neighbor_count, 0);
    chk("arst_type", result_type, 0);
    chk("arst_votes", result_votes, 0);
    chk("arst_valid", result_valid, 0);
    tick();
    rst = 1'b1;
    m_clear();
    tick();

    do_start();
    send(20, 1, 0);
    send(20, 2, 0);
    send(20, 3, 0);
    send(20, 2, 0);
    send_eod(1);
    wait_result();

    do_start();
    send(5, 3, 0);
    send(7, 3, 1);
    wait_result();

    do_start();
    send_eod(1);
    wait_result();

    do_start();
    send(1, 3, 0);
    send(2, 3, 0);
    send_eod(0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_clear();
    chk("abort_busy", busy, 1);
    chk("abort_count", neighbor_count, 0);
    send(9, 2, 1);
    wait_result();

    for (int q = 0; q < 40; q++) begin
      int n;
      bit co;
      do_start();
      n  = $urandom_range(0, 8);
      co = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        int d;
        if ($urandom_range(0, 3) == 0) tick();
        d = ($urandom_range(0, 9) == 0) ? 65535 : $urandom_range(0, 63);
        send(d, $urandom_range(0, NT - 1), co && (i == n - 1));
      end
      if (!(co && n > 0)) send_eod(1);
      wait_result();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
